log18_q3_12_seq: RTL and testbench



---
 rtl/log18_q3_12_seq.sv | 120 ++++++++++++
 tb/tb_log18_q3_12_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/log18_q3_12_seq.sv
// rtl/log18_q3_12_seq.sv - serial linear Q3.12 to 18-bit log2 converter
module log18_q3_12_seq #(
  parameter logic [17:0] LOG_ZERO = 18'h20000,
  parameter int          EXP_TOP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_log,
  output logic        out_sign,
  output logic        out_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] EXP_INIT = 6'(EXP_TOP);

  logic [1:0]  state_q, state_d;
  logic [14:0] sr_q, sr_d;
  logic [5:0]  exp_q, exp_d;
  logic [17:0] log_q, log_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;

  logic [15:0] neg_w;
  logic [14:0] mag_w;

  // Magnitude of the incoming sample; -8.0 has no positive twin and saturates.
  always_comb begin
    neg_w = (~in_data) + 16'd1;
    mag_w = in_data[14:0];
    if (in_data[15]) begin
      if (in_data == 16'h8000) begin
        mag_w = 15'h7FFF;
      end else begin
        mag_w = neg_w[14:0];
      end
    end
  end

  // Next-state logic: accept, shift one bit per clock until bit 14 is set, then hold.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    exp_d   = exp_q;
    log_d   = log_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_data[15];
          if (mag_w == 15'd0) begin
            log_d   = LOG_ZERO;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            sr_d    = mag_w;
            exp_d   = EXP_INIT;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (sr_q[14]) begin
          // Mitchell fraction: the bits below the leading one, low two truncated.
          log_d   = {exp_q, sr_q[13:2]};
          zero_d  = 1'b0;
          state_d = DONE;
        end else begin
          sr_d  = {sr_q[13:0], 1'b0};
          exp_d = exp_q - 6'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset that discards any in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 15'd0;
      exp_q   <= 6'd0;
      log_q   <= 18'd0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      exp_q   <= exp_d;
      log_q   <= log_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake flags decode straight from state so they cannot disagree with it.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_log   = log_q;
    out_sign  = sign_q;
    out_zero  = zero_q;
  end

endmodule

// File: tb/tb_log18_q3_12_seq.sv
// tb/tb_log18_q3_12_seq.sv - self-checking bench for log18_q3_12_seq
module tb_log18_q3_12_seq;

  localparam logic [17:0] LOG_ZERO = 18'h20000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_log;
  logic        out_sign;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  log18_q3_12_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_log  (out_log),
    .out_sign (out_sign),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: log2 of the magnitude with the leading one at position p,
  // exponent p-12 (so bit 14 maps to 2), fraction floor((m/2^p - 1) * 4096).
  // lat = edges after the accept edge until out_valid; a zero sample goes
  // straight to DONE on the accept edge itself.
  function automatic logic [17:0] ref_log(input logic [15:0] d, output int lat);
    int v;
    int m;
    int p;
    int e;
    int f;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    if (m == 0) begin
      lat = 0;
      return LOG_ZERO;
    end
    p = $clog2(m + 1) - 1;
    e = p - 12;
    f = ((m - (1 << p)) * 4096) >> p;
    lat = (14 - p) + 1;
    return {6'(e), 12'(f)};
  endfunction

  // Value the antilog would produce from a log word (Q3.12 magnitude).
  function automatic int antilog(input logic [17:0] l);
    int e;
    int mant;
    e = int'($signed(l[17:12]));
    mant = 4096 + int'(l[11:0]);
    if (e >= 0) return mant << e;
    return mant >> (-e);
  endfunction

  task automatic convert(input logic [15:0] d, input int hold, input bit noise, output logic [17:0] got);
    logic [17:0] el;
    int elat;
    int lat;
    int v;
    el = ref_log(d, elat);
    v = int'($signed(d));
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("out_valid_rise", {31'd0, out_valid}, 32'd1);
    chk("latency", lat, elat);
    chk("out_log", {14'd0, out_log}, {14'd0, el});
    chk("out_sign", {31'd0, out_sign}, {31'd0, d[15]});
    chk("out_zero", {31'd0, out_zero}, (v == 0) ? 32'd1 : 32'd0);
    got = out_log;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_log", {14'd0, out_log}, {14'd0, el});
      chk("hold_sign", {31'd0, out_sign}, {31'd0, d[15]});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consumed_valid", {31'd0, out_valid}, 32'd0);
    chk("consumed_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [17:0] got;
    logic [15:0] dirs [9];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_log", {14'd0, out_log}, 32'd0);
    chk("rst_out_sign", {31'd0, out_sign}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);

    dirs = '{16'h1000, 16'h7FFF, 16'h8000, 16'hF000, 16'h1800,
             16'h0001, 16'h0000, 16'hFFFF, 16'h4000};
    for (int i = 0; i < 9; i++) begin
      convert(dirs[i], 0, 1'b0, got);
    end

    convert(16'h1800, 0, 1'b0, got);
    chk("roundtrip_1800", antilog(got), 32'h1800);

    convert(16'h2345, 5, 1'b0, got);
    convert(16'h0003, 2, 1'b1, got);

    convert(16'h1000, 0, 1'b0, got);
    chk("b2b_first", {14'd0, got}, 32'h00000);
    convert(16'h0400, 0, 1'b0, got);
    chk("b2b_second", {14'd0, got}, 32'h3E000);

    // Reset while 0x0001 is still normalising.
    @(negedge clk);
    in_data  = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_log", {14'd0, out_log}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    convert(16'h0C00, 1, 1'b0, got);

    for (int i = 0; i < 60; i++) begin
      convert(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
